// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: buffers (pc, instr) pairs in a small FIFO
// and presents the head entry with RV32I field extraction and immediate.
module if_id_queue #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [PTR_W:0]   count
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem_pc_q    [DEPTH];
    logic [31:0]      mem_pc_d    [DEPTH];
    logic [31:0]      mem_instr_q [DEPTH];
    logic [31:0]      mem_instr_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (flush) begin
            // storage is intentionally left intact; only bookkeeping is cleared
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_pc_d[wr_ptr_q]    = in_pc;
                mem_instr_d[wr_ptr_q] = in_instr;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic        opcode_known;

    // Head is masked to zero when empty, so every derived field reads zero too.
    always_comb begin
        head_pc    = out_valid ? mem_pc_q[rd_ptr_q]    : '0;
        head_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;

        out_pc     = head_pc;
        out_instr  = head_instr;
        out_opcode = head_instr[6:0];
        out_rd     = head_instr[11:7];
        out_funct3 = head_instr[14:12];
        out_rs1    = head_instr[19:15];
        out_rs2    = head_instr[24:20];
        out_funct7 = head_instr[31:25];

        out_imm      = '0;
        opcode_known = 1'b1;
        case (head_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                out_imm = {{20{head_instr[31]}}, head_instr[31:20]};
            OP_STORE:
                out_imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
            OP_BRANCH:
                out_imm = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                           head_instr[30:25], head_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                out_imm = {head_instr[31:12], 12'b0};
            OP_JAL:
                out_imm = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                           head_instr[20], head_instr[30:21], 1'b0};
            OP_REG, OP_SYSTEM, OP_FENCE:
                out_imm = '0;
            default: begin
                out_imm      = '0;
                opcode_known = 1'b0;
            end
        endcase

        // every listed opcode ends in 2'b11, so the list check also covers instr[1:0]
        out_illegal = out_valid && !opcode_known;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receiving end of the instruction fetch interface: accepts (pc, instruction) pairs from the fetch stage into a small FIFO.
- Presents the oldest entry to the decode stage together with RV32I field extraction and a sign-extended immediate.
- Provides back-pressure to fetch (in_ready) and a flush path for taken branches/exceptions.
- Sits between the fetch stage and the register-read/decode stage.

Parameters:
DEPTH, 2, number of queue entries; power of two, >= 2
PTR_W, 1, log2(DEPTH); pointer width, count register is PTR_W+1 bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
flush  input  1  synchronous queue clear; discards all entries
in_valid  input  1  fetch presents a valid pair this cycle
in_pc  input  32  PC of fetched instruction
in_instr  input  32  fetched instruction word
in_ready  output  1  queue can accept (count != DEPTH)
out_valid  output  1  head entry valid (count != 0)
out_ready  input  1  decode consumes head this cycle
out_pc  output  32  head PC
out_instr  output  32  head instruction
out_opcode  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_funct3  output  3  instr[14:12]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_funct7  output  7  instr[31:25]
out_imm  output  32  sign-extended immediate per format
out_illegal  output  1  head is not a supported RV32I opcode
count  output  PTR_W+1  current occupancy

Behaviour:
- Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, all storage=0. Outputs during/after reset: in_ready=1, out_valid=0, all out_* data fields=0, count=0.
- Push when in_valid && in_ready && !flush: write {in_pc,in_instr} at wr_ptr; wr_ptr+1 mod DEPTH.
- Pop when out_valid && out_ready && !flush: rd_ptr+1 mod DEPTH.
- Push and pop in the same cycle: both pointers advance, count unchanged.
- No bypass. An entry pushed into an empty queue gives out_valid=1 on the next cycle. Latency is exactly 1 cycle.
- Full: in_ready=0, so in_valid is ignored even if a pop happens that cycle; in_ready rises the cycle after the pop.
- Empty: out_valid=0; out_ready is ignored; count stays 0 (no underflow).
- Flush: takes priority over push and pop in the same cycle. Next cycle: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1. Storage contents are not cleared.
- Pointers wrap modulo DEPTH. count is always in 0..DEPTH.
- Output data is combinational from the head entry. When out_valid=0, all out_* data fields are forced to 0.
- Immediate, by opcode:
  - 0010011, 0000011, 1100111 (I): sext(instr[31:20])
  - 0100011 (S): sext({instr[31:25],instr[11:7]})
  - 1100011 (B): sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - 0110111, 0010111 (U): {instr[31:12],12'b0}
  - 1101111 (J): sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - 0110011 (R), 1110011, 0001111 and all others: 0
- out_illegal=1 when out_valid && (instr[1:0]!=2'b11 or opcode is not one of the eleven listed above). When out_valid=0, out_illegal=0.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.

Test Plan:
- Reset release, no traffic -> in_ready=1, out_valid=0, count=0, out_imm=0, out_illegal=0.
- Push pc=0x0, instr=0x00500093 (addi x1,x0,5), out_ready=0 -> next cycle out_valid=1, out_opcode=0x13, out_rd=1, out_rs1=0, out_funct3=0, out_imm=0x00000005, out_illegal=0.
- Push 0x0020A423 (sw x2,8(x1)) then 0xFE000EE3 (beq x0,x0,-4), out_ready=0 -> count=2, in_ready=0, head imm=0x00000008 with rs1=1, rs2=2. A third push at pc=0x8 is rejected. Then pop one -> head imm=0xFFFFFFFC; in_ready=1 the following cycle.
- Queue at count=1, continuous push+pop for 6 cycles with pc=0x0,0x4,...,0x14 -> count stays 1; out_pc sequence lags in_pc by 1 cycle across pointer wrap; no entry is lost or duplicated.
- count=2 with flush, in_valid and out_ready all asserted together -> next cycle count=0, out_valid=0, in_ready=1; the flushed-cycle push is not stored.
- Push 0x00000000 -> out_illegal=1, out_imm=0. Assert reset asynchronously mid-cycle with count=2 -> out_valid=0 and count=0 before the next clock edge.
